mem_lock_arbiter: RTL
=====================

Name: mem_lock_arbiter

Overview:
- Sits between the C cores and the shared data memory (`dmem`).
- Arbitrates the cores' main-memory read/write requests round-robin and serialises them onto a single synchronous memory port.
- Returns read data and a one-cycle `main_mem_ac` to the granted core.
- Holds a lock table: one 10-bit lock address per core, granting `lock_ac` only when no other core holds that address.

Parameters:
- C, 2, number of cores; valid range 2..8.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- main_mem_read_adr  in  C*16  per-core read address; core i occupies bits [16i+15:16i].
- main_mem_write_adr  in  C*16  per-core write address.
- main_mem_write_dat  in  C*16  per-core write data.
- main_mem_read  in  C  per-core read request; held until ack.
- main_mem_write  in  C  per-core write request; held until ack.
- main_mem_ac  out  C  one-cycle acknowledge to the served core.
- main_mem_dat  out  16  read data broadcast to all cores; valid when the matching `main_mem_ac` bit is 1.
- lock_adr  in  C*10  per-core lock address.
- lock_en  in  C  per-core lock request; held until `lock_ac`.
- unlock_en  in  C  per-core release of the held lock; single-cycle.
- lock_ac  out  C  one-cycle lock grant.
- mem_adr  out  16  address to the memory.
- mem_wdat  out  16  write data to the memory.
- mem_we  out  1  memory write enable.
- mem_rdat  in  16  synchronous memory read data, valid one cycle after `mem_adr`.

Behaviour:
- Reset (async, active-high):
  - `main_mem_ac`=0, `lock_ac`=0, `mem_we`=0, `mem_adr`=0, `mem_wdat`=0, `main_mem_dat`=0.
  - FSM=IDLE, rr_ptr=0, every lock entry invalid.
  - Reset asserted mid-transaction aborts it: no ac is issued, and a write already in ISSUE may or may not have reached memory.
- Memory FSM:
  - IDLE: req[i] = `main_mem_read[i]` | `main_mem_write[i]`. If any req is set, pick the first i at or after rr_ptr (wrapping modulo C). Register the winner and its op, drive `mem_adr`/`mem_wdat`/`mem_we` from it, go to ISSUE. If no req, stay in IDLE.
  - Op choice: write if `main_mem_write[i]` is set, else read. A core asserting both gets the write only, with a single ack.
  - Address choice: `mem_adr` = `main_mem_write_adr` for writes, `main_mem_read_adr` for reads.
  - ISSUE: memory samples the registered outputs. `mem_we` drops to 0 at the end of ISSUE. Go to RESP.
  - RESP: `main_mem_ac[winner]`=1 for exactly this cycle and `main_mem_dat`=`mem_rdat` (read) or unchanged (write). Set rr_ptr=(winner+1) mod C. Go to IDLE.
- Latency: request first seen in IDLE at cycle N gives ack in cycle N+2; a new grant is possible at N+3. Worst-case wait for a core is 3*C cycles.
- Core protocol: a core keeps its request and operands stable until it sees ack, and deasserts in the following cycle. The arbiter never acks a core twice for one request.
- Lock table, evaluated every cycle independently of the FSM, entry per core = {valid, adr}:
  - Unlock first: `unlock_en[i]` clears entry i at the edge. Unlock with no lock held has no effect.
  - Grant condition for core i: `lock_en[i]` & ~`lock_ac[i]`, and no valid entry j≠i (after same-cycle unlocks) with adr=`lock_adr[i]`.
  - Contention: among cores requesting the same free address in one cycle, the lowest index wins; the others wait.
  - On grant: entry i <= {1, `lock_adr[i]`} and `lock_ac[i]`=1 in the next cycle, for one cycle only.
  - A denied core keeps `lock_en` asserted and is re-evaluated every cycle.
  - Re-lock by the holder (same or different address) replaces its own entry subject to the same rule. A core's own entry never blocks it.
  - Different addresses for different cores are granted in the same cycle.

Test Plan:
- Reset, then core0 reads adr 0x0010 with mem holding 0x1234 there → `mem_adr`=0x0010 in ISSUE; `main_mem_ac`=01 and `main_mem_dat`=0x1234 two cycles after the request; `mem_we` never 1.
- Core0 writes 0xBEEF to 0x0020 and core1 reads 0x0020, both in the same cycle, rr_ptr=0 → core0 acked first; core1 acked 3 cycles later with `main_mem_dat`=0xBEEF; rr_ptr=0 afterwards.
- Both cores request continuously for 12 cycles → acks alternate 01, 10, 01, 10 at a 3-cycle spacing.
- Both cores `lock_en` adr 0x005 in the same cycle → `lock_ac`=01 next cycle. Core0 then pulses `unlock_en` → `lock_ac`=10 exactly one cycle after the unlock edge.
- Core0 locks 0x001 and core1 locks 0x002 simultaneously → `lock_ac`=11 in the same cycle; each pulses once only, although `lock_en` is still high during the ack cycle.
- Reset asserted during ISSUE of a read → `main_mem_ac` stays 0, FSM=IDLE, lock table cleared, and after release the pending request is served normally.

Source files
------------

// File: rtl/mem_lock_arbiter_if.sv
// Core/memory-side bundle of the memory + lock arbiter.
// master: cores and memory (drive requests, operands, lock requests, mem_rdat).
// slave : the arbiter (drives acks, read data, lock grants, memory port).
interface mem_lock_arbiter_if #(
    parameter int unsigned C = 2
);
    localparam int unsigned DW = 16;
    localparam int unsigned LW = 10;

    logic [C*DW-1:0] main_mem_read_adr;
    logic [C*DW-1:0] main_mem_write_adr;
    logic [C*DW-1:0] main_mem_write_dat;
    logic [C-1:0]    main_mem_read;
    logic [C-1:0]    main_mem_write;
    logic [C-1:0]    main_mem_ac;
    logic [DW-1:0]   main_mem_dat;
    logic [C*LW-1:0] lock_adr;
    logic [C-1:0]    lock_en;
    logic [C-1:0]    unlock_en;
    logic [C-1:0]    lock_ac;
    logic [DW-1:0]   mem_adr;
    logic [DW-1:0]   mem_wdat;
    logic            mem_we;
    logic [DW-1:0]   mem_rdat;

    modport master (
        output main_mem_read_adr, main_mem_write_adr, main_mem_write_dat,
        output main_mem_read, main_mem_write, lock_adr, lock_en, unlock_en,
        output mem_rdat,
        input  main_mem_ac, main_mem_dat, lock_ac, mem_adr, mem_wdat, mem_we
    );

    modport slave (
        input  main_mem_read_adr, main_mem_write_adr, main_mem_write_dat,
        input  main_mem_read, main_mem_write, lock_adr, lock_en, unlock_en,
        input  mem_rdat,
        output main_mem_ac, main_mem_dat, lock_ac, mem_adr, mem_wdat, mem_we
    );
endinterface

// File: rtl/mem_lock_arbiter.sv
// Round-robin arbiter serialising C cores onto one synchronous memory port,
// plus a per-core lock table granting exclusive ownership of 10-bit addresses.
// Ports: clk, reset (async, active-high), bus (mem_lock_arbiter_if.slave).
module mem_lock_arbiter #(
    parameter int unsigned C = 2
) (
    input  logic               clk,
    input  logic               reset,
    mem_lock_arbiter_if.slave  bus
);
    localparam int unsigned PW = (C > 1) ? $clog2(C) : 1;
    localparam int unsigned DW = 16;
    localparam int unsigned LW = 10;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] rr_ptr, winner, pick;
    logic          win_write, pick_found;
    logic [C-1:0]  req;
    logic [C-1:0]  mem_ac_q;
    logic [DW-1:0] dat_q, mem_adr_q, mem_wdat_q;
    logic          mem_we_q;

    logic [C-1:0]  lk_valid, lk_eff, lk_cand, lk_grant, lock_ac_q;
    logic [LW-1:0] lk_adr [C];

    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        return PW'(s % C);
    endfunction

    // Round-robin pick: first requesting core at or after rr_ptr.
    always_comb begin
        req        = bus.main_mem_read | bus.main_mem_write;
        pick       = '0;
        pick_found = 1'b0;
        for (int unsigned k = 0; k < C; k++) begin
            if (!pick_found && req[wrap_idx(rr_ptr, k)]) begin
                pick       = wrap_idx(rr_ptr, k);
                pick_found = 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (pick_found) state_nxt = ISSUE;
            ISSUE:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory datapath: latch winner in IDLE, ack in RESP, advance pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr     <= '0;
            winner     <= '0;
            win_write  <= 1'b0;
            mem_ac_q   <= '0;
            dat_q      <= '0;
            mem_adr_q  <= '0;
            mem_wdat_q <= '0;
            mem_we_q   <= 1'b0;
        end else begin
            mem_ac_q <= '0;
            case (state)
                IDLE: if (pick_found) begin
                    winner     <= pick;
                    win_write  <= bus.main_mem_write[pick];
                    mem_we_q   <= bus.main_mem_write[pick];
                    mem_adr_q  <= bus.main_mem_write[pick]
                                  ? bus.main_mem_write_adr[32'(pick)*DW +: DW]
                                  : bus.main_mem_read_adr[32'(pick)*DW +: DW];
                    mem_wdat_q <= bus.main_mem_write_dat[32'(pick)*DW +: DW];
                end
                ISSUE: begin
                    mem_we_q <= 1'b0;
                    mem_ac_q <= C'(1) << winner;
                end
                RESP: begin
                    rr_ptr <= wrap_idx(winner, 1);
                    if (!win_write) dat_q <= bus.mem_rdat;
                end
                default: ;
            endcase
        end
    end

    // Read data arrives from memory during RESP, the same cycle as the ack,
    // so it is forwarded straight through then and held afterwards.
    assign bus.main_mem_dat = (state == RESP && !win_write) ? bus.mem_rdat : dat_q;
    assign bus.main_mem_ac  = mem_ac_q;
    assign bus.mem_adr      = mem_adr_q;
    assign bus.mem_wdat     = mem_wdat_q;
    assign bus.mem_we       = mem_we_q;

    // Lock candidates: not just acked, and no other live entry on that address.
    always_comb begin
        lk_eff  = lk_valid & ~bus.unlock_en;
        lk_cand = '0;
        for (int unsigned i = 0; i < C; i++) begin
            lk_cand[i] = bus.lock_en[i] & ~lock_ac_q[i];
            for (int unsigned j = 0; j < C; j++) begin
                if (j != i && lk_eff[j] && lk_adr[j] == bus.lock_adr[i*LW +: LW])
                    lk_cand[i] = 1'b0;
            end
        end
    end

    // Same-address contention: lowest-index candidate wins.
    always_comb begin
        lk_grant = lk_cand;
        for (int unsigned i = 1; i < C; i++) begin
            for (int unsigned k = 0; k < i; k++) begin
                if (lk_cand[k] && bus.lock_adr[k*LW +: LW] == bus.lock_adr[i*LW +: LW])
                    lk_grant[i] = 1'b0;
            end
        end
    end

    // Lock table update; a grant overrides a same-cycle unlock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lk_valid  <= '0;
            lock_ac_q <= '0;
            for (int unsigned i = 0; i < C; i++) lk_adr[i] <= '0;
        end else begin
            lock_ac_q <= lk_grant;
            for (int unsigned i = 0; i < C; i++) begin
                if (lk_grant[i]) begin
                    lk_valid[i] <= 1'b1;
                    lk_adr[i]   <= bus.lock_adr[i*LW +: LW];
                end else if (bus.unlock_en[i]) begin
                    lk_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.lock_ac = lock_ac_q;
endmodule
